// File: rtl/mem_port_master_pkg.sv
// Shared types and helpers for the combined-memory port master.
// Holds the FSM state and request-type enums plus the address check.
package mem_port_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        FETCH,
        LOAD,
        STORE
    } req_type_t;

    localparam int unsigned WORD_BYTES = 4;

    // Misaligned or beyond the end of the attached memory.
    function automatic logic addr_err(
        input logic [31:0] addr,
        input int unsigned words
    );
        return (addr[1:0] != 2'b00) || (addr >= WORD_BYTES * words);
    endfunction

endpackage

// File: rtl/mem_req_arbiter.sv
// Fetch/data request arbiter with a fairness counter.
// Ports: i_en (FSM idle), i_if_req, i_d_req -> o_grant_if, o_grant_d.
module mem_req_arbiter #(
    parameter int FAIR_LIMIT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_grant_if,
    output logic o_grant_d
);

    localparam int CW = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);

    logic [CW-1:0] r_cnt;
    logic          w_fair;

    // Fetch has waited through FAIR_LIMIT data grants in a row.
    assign w_fair = (r_cnt >= CW'(FAIR_LIMIT));

    always_comb begin
        o_grant_if = 1'b0;
        o_grant_d  = 1'b0;
        if (i_en) begin
            if (i_d_req && !(i_if_req && w_fair)) begin
                o_grant_d = 1'b1;
            end else if (i_if_req) begin
                o_grant_if = 1'b1;
            end
        end
    end

    // A data grant only counts while a fetch is left waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (o_grant_if) begin
            r_cnt <= '0;
        end else if (o_grant_d) begin
            r_cnt <= i_if_req ? r_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/mem_port_master.sv
// Single-port memory master shared by instruction fetch and data access.
// Ports: if_* fetch side, d_* data side, mem_* memory port, busy status.
module mem_port_master
    import mem_port_master_pkg::*;
#(
    parameter int MEM_WORDS  = 64,
    parameter int FAIR_LIMIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_read,
    output logic        busy
);

    state_t      r_state;
    state_t      w_next_state;
    req_type_t   r_type;
    req_type_t   w_type;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_idle;
    logic        w_access;
    logic        w_resp;
    logic        w_grant_if;
    logic        w_grant_d;
    logic        w_accept;
    logic [31:0] w_addr;
    logic        w_err;

    assign w_idle   = (r_state == IDLE);
    assign w_access = (r_state == ACCESS);
    assign w_resp   = (r_state == RESP);

    mem_req_arbiter #(
        .FAIR_LIMIT(FAIR_LIMIT)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .i_en      (w_idle),
        .i_if_req  (if_req),
        .i_d_req   (d_req),
        .o_grant_if(w_grant_if),
        .o_grant_d (w_grant_d)
    );

    assign w_accept = w_grant_if | w_grant_d;
    assign w_addr   = w_grant_d ? d_addr : if_addr;
    assign w_err    = addr_err(w_addr, int'(MEM_WORDS));

    always_comb begin
        w_type = FETCH;
        if (w_grant_d) begin
            w_type = d_we ? STORE : LOAD;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    // Bad addresses never touch memory.
                    w_next_state = w_err ? RESP : ACCESS;
                end
            end
            ACCESS:  w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_type     <= FETCH;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_type  <= w_type;
                r_addr  <= w_addr;
                r_wdata <= d_wdata;
                r_err   <= w_err;
                // Error responses return zero data on the next cycle.
                if (w_err) begin
                    if (w_grant_if) begin
                        r_if_rdata <= '0;
                    end else begin
                        r_d_rdata <= '0;
                    end
                end
            end
            if (w_access) begin
                if (r_type == FETCH) begin
                    r_if_rdata <= mem_read;
                end else if (r_type == LOAD) begin
                    r_d_rdata <= mem_read;
                end
            end
        end
    end

    // Memory port is decoded from state so reset kills it immediately.
    assign mem_addr  = w_access ? r_addr : '0;
    assign mem_we    = w_access && (r_type == STORE);
    assign mem_wdata = mem_we ? r_wdata : '0;

    assign if_valid  = w_resp && (r_type == FETCH);
    assign d_valid   = w_resp && (r_type != FETCH);
    assign if_err    = if_valid && r_err;
    assign d_err     = d_valid && r_err;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign busy      = !w_idle;

endmodule

// File: tb/tb_mem_port_master.sv
// Directed bench for mem_port_master with a 64-word memory model.
// Covers load/store, arbitration, address errors, reset abort, back-to-back.
module tb_mem_port_master;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_read;
    logic        busy;

    mem_port_master #(
        .MEM_WORDS (64),
        .FAIR_LIMIT(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_valid (if_valid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .mem_read (mem_read),
        .busy     (busy)
    );

    logic [31:0] mem [0:63];

    assign mem_read = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int dv_cnt = 0;
    int both_cnt = 0;
    int errbad_cnt = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (d_valid) dv_cnt++;
        if (if_valid && d_valid) both_cnt++;
        if ((if_err && !if_valid) || (d_err && !d_valid)) errbad_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Issue one request, wait (bounded) for its valid, drop req after it.
    task automatic xact(input logic is_d, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd,
                        output logic er, output logic [31:0] a1);
        logic v;
        lat = -1;
        rd  = '0;
        er  = 1'b0;
        a1  = '0;
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 1; c <= 8; c++) begin
            step();
            smp();
            if (c == 1) a1 = mem_addr;
            v = is_d ? d_valid : if_valid;
            if (v) begin
                lat = c;
                rd  = is_d ? d_rdata : if_rdata;
                er  = is_d ? d_err : if_err;
                break;
            end
        end
        step();
        d_req  = 1'b0;
        if_req = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] a1;
    int          we0;
    int          dv0;
    int          c0;
    logic [5:0]  gseq;
    logic [5:0]  gexp;
    int          ng;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0]  = 32'h11;
        mem[1]  = 32'h22;
        mem[32] = 32'd12;
        mem[33] = 32'd10;
        reset = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        d_req = 1'b1;
        if_req = 1'b1;
        step();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_valid", {30'd0, if_valid, d_valid}, 0);
        check("rst_mem", {31'd0, mem_we} | mem_addr, 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        d_req = 1'b0;
        if_req = 1'b0;
        step();
        reset = 1'b0;

        // Load 0x80, first request after reset release.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        smp();
        check("ld_pre_addr", mem_addr, 0);
        step();
        smp();
        check("ld_acc_addr", mem_addr, 32'h80);
        check("ld_acc_valid", {31'd0, d_valid}, 0);
        step();
        smp();
        check("ld_resp_valid", {31'd0, d_valid}, 1);
        check("ld_resp_rdata", d_rdata, 32'd12);
        check("ld_resp_err", {31'd0, d_err}, 0);
        check("ld_resp_addr", mem_addr, 0);
        step();
        d_req = 1'b0;
        smp();
        check("ld_idle_busy", {31'd0, busy}, 0);

        // Store 15 to 0x90 then load it back.
        step();
        we0 = we_cnt;
        xact(1'b1, 1'b1, 32'h90, 32'd15, lat, rd, er, a1);
        check("st_lat", lat, 2);
        check("st_addr", a1, 32'h90);
        check("st_we_cycles", we_cnt - we0, 1);
        check("st_keeps_rdata", rd, 32'd12);
        xact(1'b1, 1'b0, 32'h90, 32'd0, lat, rd, er, a1);
        check("st_ld_rdata", rd, 32'd15);

        // Both requests held high: D D F D D F.
        gexp = 6'b011011;
        gseq = '0;
        ng = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        if_req = 1'b1; if_addr = 32'h0;
        for (int c = 0; c < 40; c++) begin
            smp();
            if (if_valid || d_valid) begin
                gseq[ng] = d_valid;
                ng++;
            end
            step();
            if (ng == 6) break;
        end
        d_req = 1'b0;
        if_req = 1'b0;
        check("arb_count", ng, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("arb_%0d", k), {31'd0, gseq[k]},
                  {31'd0, gexp[k]});
        end

        // Misaligned load and out-of-range fetch.
        step();
        we0 = we_cnt;
        xact(1'b1, 1'b0, 32'h82, 32'd0, lat, rd, er, a1);
        check("mis_lat", lat, 1);
        check("mis_err", {31'd0, er}, 1);
        check("mis_rdata", rd, 0);
        check("mis_addr", a1, 0);
        xact(1'b0, 1'b0, 32'h100, 32'd0, lat, rd, er, a1);
        check("oor_lat", lat, 1);
        check("oor_err", {31'd0, er}, 1);
        check("oor_rdata", rd, 0);
        check("err_no_we", we_cnt - we0, 0);

        // Reset during the ACCESS cycle of a store.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h84; d_wdata = 32'd99;
        step();
        dv0 = dv_cnt;
        check("rab_we_pre", {31'd0, mem_we}, 1);
        #2;
        reset = 1'b1;
        #1;
        check("rab_we_drop", {31'd0, mem_we}, 0);
        check("rab_busy", {31'd0, busy}, 0);
        d_req = 1'b0;
        d_we = 1'b0;
        smp();
        reset = 1'b0;
        repeat (4) step();
        check("rab_no_valid", dv_cnt - dv0, 0);
        check("rab_word33", mem[33], 32'd10);
        xact(1'b1, 1'b0, 32'h84, 32'd0, lat, rd, er, a1);
        check("rab_ld_rdata", rd, 32'd10);

        // Back-to-back fetches 0x0 then 0x4.
        if_req = 1'b1; if_addr = 32'h0;
        step();
        smp();
        check("bb_acc0_busy", {31'd0, busy}, 1);
        step();
        smp();
        c0 = cyc;
        check("bb_v0", {31'd0, if_valid}, 1);
        check("bb_rd0", if_rdata, 32'h11);
        step();
        if_addr = 32'h4;
        smp();
        check("bb_idle_busy", {31'd0, busy}, 0);
        step();
        smp();
        check("bb_acc1_busy", {31'd0, busy}, 1);
        check("bb_acc1_addr", mem_addr, 32'h4);
        step();
        smp();
        check("bb_v1", {31'd0, if_valid}, 1);
        check("bb_rd1", if_rdata, 32'h22);
        check("bb_period", cyc - c0, 3);
        step();
        if_req = 1'b0;
        smp();
        check("bb_end_busy", {31'd0, busy}, 0);

        check("one_valid", both_cnt, 0);
        check("err_only_valid", errbad_cnt, 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_master.md
MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 The block SHALL have these parameters:
- MEM_WORDS, default 64, number of 32-bit words in the attached combined memory.
- FAIR_LIMIT, default 2, consecutive data grants allowed while a fetch is waiting.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  instruction fetch request; held until if_valid.
- if_addr  in  32  fetch byte address.
- if_valid  out  1  one-cycle fetch completion pulse.
- if_rdata  out  32  fetched word; held until the next fetch completes.
- if_err  out  1  error flag for the fetch; valid with if_valid.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load; held with d_req.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_valid  out  1  one-cycle data completion pulse.
- d_rdata  out  32  load word; held until the next load completes.
- d_err  out  1  error flag for the data access; valid with d_valid.
- mem_addr  out  32  byte address to memory.
- mem_wdata  out  32  write data to memory.
- mem_we  out  1  memory write enable; memory writes on the rising clk edge.
- mem_read  in  32  combinational memory read data for mem_addr.
- busy  out  1  1 whenever the state is not IDLE.

Function
REQ-003 The controller SHALL be a three-state FSM:
- IDLE: samples requests on each edge.
- ACCESS: drives the memory port for exactly one cycle.
- RESP: asserts exactly one valid pulse for exactly one cycle, then returns to IDLE.

REQ-004 Accept/issue timing: a request sampled high at IDLE edge N SHALL be latched into internal address, write-data and type registers. The block SHALL be in ACCESS during cycle N+1 and in RESP during cycle N+2. Latency from acceptance to valid is 2 cycles.

REQ-005 Memory port during ACCESS:
- mem_addr SHALL equal the latched address.
- For a store, mem_wdata SHALL equal the latched d_wdata and mem_we SHALL be 1.
- For a load or fetch, mem_we SHALL be 0.

REQ-006 Memory port outside ACCESS: mem_addr, mem_wdata and mem_we SHALL be 0. mem_we SHALL never be high for more than one cycle per accepted store.

REQ-007 Read capture: on the edge ending ACCESS, mem_read SHALL be registered into if_rdata (fetch) or d_rdata (load). Stores SHALL leave d_rdata unchanged.

REQ-008 Arbitration when both requests are high in IDLE:
- d_req SHALL win.
- Exception: after FAIR_LIMIT consecutive data grants with if_req high throughout, the fetch SHALL win.
- The consecutive-grant counter SHALL clear on any fetch grant, or when if_req is low at a grant.

REQ-009 Address errors: an address is in error if addr[1:0] != 0 or addr >= 4*MEM_WORDS. Such a request SHALL:
- go IDLE -> RESP directly, with no ACCESS cycle and no memory write;
- assert the matching err flag with its valid pulse;
- set the matching rdata to 0.

REQ-010 Err and valid pulses:
- err flags SHALL be 0 in any cycle where their valid is 0.
- Only one of if_valid and d_valid SHALL ever be high in a cycle.

REQ-011 The requester drops its req on the edge after seeing valid. A req still high in the IDLE cycle after RESP SHALL be treated as a new request.

REQ-012 Inputs SHALL be ignored outside IDLE. Requests that change mid-transaction SHALL NOT affect the latched transaction.

Reset
REQ-013 Asserting reset SHALL force, immediately and without a clock edge:
- state IDLE;
- all outputs 0, including if_rdata, d_rdata and busy;
- the fairness counter 0.

REQ-014 Reset asserted during ACCESS of a store SHALL drop mem_we immediately, so no write occurs. The aborted transaction SHALL produce no valid pulse after reset releases.

REQ-015 After reset deasserts, the first request SHALL be sampled on the first rising clk edge.

Structure
REQ-016 A shared package SHALL hold:
- the state enum {IDLE, ACCESS, RESP};
- the request-type enum {FETCH, LOAD, STORE};
- constant WORD_BYTES = 4.

REQ-017 Arbitration and the fairness counter SHALL live in one sub-module, mem_req_arbiter. The FSM and datapath registers SHALL live in mem_port_master.

Verification
REQ-018 The bench SHALL pair the block with a 64-word memory model: combinational read, write on posedge when mem_we is high. The model SHALL be preloaded with word 32 = 12 and word 33 = 10. Directed scenarios:
- Load 0x80 accepted at edge N -> d_valid high in cycle N+2, d_rdata = 12, d_err = 0; mem_addr = 0x80 only in cycle N+1.
- Store 0x90, data 15, then load 0x90 -> mem_we high exactly one cycle; load returns 15.
- if_req and d_req held high continuously -> grant order D, D, F, D, D, F.
- Load 0x82 (misaligned) and fetch 0x100 (out of range) -> valid 1 cycle after acceptance, err = 1, rdata = 0, mem_we never high.
- Reset pulsed during ACCESS of store 0x84, data 99 -> mem_we drops immediately; word 33 still reads 10; no d_valid follows.
- Back-to-back fetches 0x0, 0x4 with req dropped on valid -> one transaction per 3 cycles; busy low only in IDLE.
